// File: rtl/bomb_fuse_queue.sv
// bomb_fuse_queue: FIFO of placed bombs, each expiring FUSE_TICKS after placement.
// Build option BOMB_DUP_CHECK_EN: reject a placement on a tile holding a live bomb.
module bomb_fuse_queue #(
  parameter int DEPTH      = 4,
  parameter int FUSE_TICKS = 192
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [11:0]                timer,
  input  logic                       place_req,
  input  logic [3:0]                 place_x,
  input  logic [3:0]                 place_y,
  output logic                       place_ack,
  output logic                       place_nack,
  output logic                       explode_valid,
  output logic [3:0]                 explode_x,
  output logic [3:0]                 explode_y,
  input  logic                       explode_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [11:0]   FUSE = 12'(FUSE_TICKS);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    x_mem  [DEPTH];
  logic [3:0]    y_mem  [DEPTH];
  logic [11:0]   ts_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic        dup;
  logic        accept;
  logic        pop;
  logic        expired;
  logic        load;
  logic [11:0] age;

`ifdef BOMB_DUP_CHECK_EN
  logic [DEPTH-1:0] live;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && x_mem[i] == place_x &&
          y_mem[i] == place_y)
        dup = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      live <= '0;
    end else begin
      if (pop)
        live[rd_ptr] <= 1'b0;
      if (accept)
        live[wr_ptr] <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Fullness is judged on the count before any same-cycle pop.
  assign accept = place_req && (count < FULL) && !dup;
  assign pop    = explode_valid && explode_ready;

  // Modulo-4096 subtraction keeps the age correct across timer wrap.
  assign age     = timer - ts_mem[rd_ptr];
  assign expired = (count != '0) && (age >= FUSE);

  assign explode_valid = (state == PRESENT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (expired) begin
          state_nxt = PRESENT;
          load      = 1'b1;
        end
      end
      PRESENT: begin
        if (explode_ready)
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      x_mem[wr_ptr]  <= place_x;
      y_mem[wr_ptr]  <= place_y;
      ts_mem[wr_ptr] <= timer;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      place_ack  <= 1'b0;
      place_nack <= 1'b0;
      explode_x  <= '0;
      explode_y  <= '0;
    end else begin
      place_ack  <= accept;
      place_nack <= place_req && !accept;
      if (accept)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (load) begin
        explode_x <= x_mem[rd_ptr];
        explode_y <= y_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_bomb_fuse_queue.sv
// tb_bomb_fuse_queue: randomized scoreboard bench for bomb_fuse_queue.
// A queue-level reference model predicts acks, explosions and count.
module tb_bomb_fuse_queue;

  localparam int DEPTH = 4;
  localparam int FUSE  = 192;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [11:0] timer = '0;
  logic        place_req = 1'b0;
  logic [3:0]  place_x = '0;
  logic [3:0]  place_y = '0;
  logic        place_ack;
  logic        place_nack;
  logic        explode_valid;
  logic [3:0]  explode_x;
  logic [3:0]  explode_y;
  logic        explode_ready = 1'b0;
  logic [2:0]  count;

  bomb_fuse_queue #(
    .DEPTH(DEPTH),
    .FUSE_TICKS(FUSE)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .timer(timer),
    .place_req(place_req),
    .place_x(place_x),
    .place_y(place_y),
    .place_ack(place_ack),
    .place_nack(place_nack),
    .explode_valid(explode_valid),
    .explode_x(explode_x),
    .explode_y(explode_y),
    .explode_ready(explode_ready),
    .count(count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [11:0] ts;
  } bomb_t;

  typedef struct {
    logic ack;
    int   cyc;
  } pl_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    int         cyc;
  } ex_t;

  bomb_t bq[$];
  pl_t   exp_pl[$];
  ex_t   exp_ex[$];

  int cyc = 0;
  bit m_pres = 1'b0;
  int m_count = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, act, exp, cyc);
  endtask

  // Reference model: live bombs as a queue, one shown bomb.
  initial forever begin
    @(posedge Clk);
    cyc++;
    if (Reset) begin
      bq.delete();
      exp_pl.delete();
      exp_ex.delete();
      m_pres = 1'b0;
    end else begin
      bit pop;
      bit dup;
      bit acc;
      bit fire;
      pop = m_pres && explode_ready;
      dup = 1'b0;
`ifdef BOMB_DUP_CHECK_EN
      foreach (bq[i])
        if (bq[i].x == place_x && bq[i].y == place_y)
          dup = 1'b1;
`endif
      acc = place_req && bq.size() < DEPTH && !dup;
      if (place_req)
        exp_pl.push_back('{acc, cyc});
      fire = !m_pres && bq.size() > 0 &&
             12'(timer - bq[0].ts) >= 12'(FUSE);
      if (fire)
        exp_ex.push_back('{bq[0].x, bq[0].y, cyc});
      m_pres = m_pres ? !pop : fire;
      if (pop)
        void'(bq.pop_front());
      if (acc)
        bq.push_back('{place_x, place_y, timer});
    end
    m_count = bq.size();
  end

  // Monitor: compares whatever the DUT presents.
  logic [3:0] hx = '0;
  logic [3:0] hy = '0;
  bit         pv = 1'b0;

  initial forever begin
    @(negedge Clk);
    if (Reset) begin
      pv = 1'b0;
    end else begin
      chk("count", count, m_count);
      chk("valid", explode_valid, m_pres);
      if (place_ack || place_nack) begin
        if (exp_pl.size() == 0) begin
          chk("place_unexpected",
              {place_ack, place_nack}, 0);
        end else begin
          pl_t e;
          e = exp_pl.pop_front();
          chk("place_ack", place_ack, e.ack);
          chk("place_nack", place_nack, !e.ack);
          chk("place_cycle", cyc, e.cyc);
        end
      end
      if (explode_valid && !pv) begin
        if (exp_ex.size() == 0) begin
          chk("explode_unexpected", explode_valid, 0);
        end else begin
          ex_t e;
          e = exp_ex.pop_front();
          chk("explode_x", explode_x, e.x);
          chk("explode_y", explode_y, e.y);
          chk("explode_cycle", cyc, e.cyc);
        end
        hx = explode_x;
        hy = explode_y;
      end else if (explode_valid) begin
        chk("hold_x", explode_x, hx);
        chk("hold_y", explode_y, hy);
      end
      pv = explode_valid;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    timer = timer + 12'd1;
  endtask

  task automatic place(input logic [3:0] x,
                       input logic [3:0] y);
    place_req = 1'b1;
    place_x   = x;
    place_y   = y;
    tick();
    place_req = 1'b0;
  endtask

  task automatic drain();
    explode_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (bq.size() == 0 && !m_pres)
        break;
      tick();
    end
    tick();
    chk("drain_count", count, 0);
  endtask

  task automatic wait_present();
    for (int i = 0; i < 600; i++) begin
      if (explode_valid)
        break;
      tick();
    end
    chk("present_wait", explode_valid, 1);
  endtask

  initial begin
    #1;
    Reset = 1'b1;
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", explode_valid, 0);
    chk("rst_ack", place_ack, 0);
    chk("rst_nack", place_nack, 0);
    chk("rst_x", explode_x, 0);
    chk("rst_y", explode_y, 0);
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Basic placement and expiry.
    timer = 12'd100;
    explode_ready = 1'b1;
    place(4'd3, 4'd5);
    drain();

    // Age across timer wrap.
    timer = 12'd4000;
    place(4'd7, 4'd9);
    drain();

    // Same tile twice.
    place(4'd2, 4'd2);
    place(4'd2, 4'd2);
    drain();

    // Overfill, stall, then pop with a same-cycle request.
    explode_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      place(4'(i), 4'(15 - i));
    wait_present();
    repeat (10) tick();
    explode_ready = 1'b1;
    place(4'd9, 4'd9);
    drain();

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      place_req = ($urandom_range(0, 7) == 0);
      place_x   = 4'($urandom_range(0, 3));
      place_y   = 4'($urandom_range(0, 3));
      explode_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    place_req = 1'b0;
    drain();

    // Reset while a bomb is being presented.
    explode_ready = 1'b0;
    place(4'd4, 4'd6);
    place(4'd8, 4'd1);
    place(4'd5, 4'd5);
    wait_present();
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_mid_valid", explode_valid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_x", explode_x, 0);
    tick();
    tick();
    Reset = 1'b0;
    explode_ready = 1'b1;
    repeat (400) tick();

    chk("pending_place", exp_pl.size(), 0);
    chk("pending_explode", exp_ex.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bomb_fuse_queue.md
BOMB_FUSE_QUEUE -- requirements
Module: bomb_fuse_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum number of live bombs held.
REQ-002 SHALL have parameter FUSE_TICKS, default 192: fuse length in 64 Hz ticks (3 s); legal range 1..2047.
REQ-003 Clk  input  1  system clock; every register SHALL be clocked on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 timer  input  12  free-running 64 Hz tick count; wraps 4095 -> 0.
REQ-006 place_req  input  1  one-cycle pulse requesting a bomb placement.
REQ-007 place_x, place_y  input  4 each  tile coordinates of the requested bomb.
REQ-008 place_ack  output  1  one-cycle pulse: the request was accepted.
REQ-009 place_nack  output  1  one-cycle pulse: the request was rejected.
REQ-010 explode_valid  output  1  an expired bomb is presented.
REQ-011 explode_x, explode_y  output  4 each  coordinates of the presented bomb.
REQ-012 explode_ready  input  1  the consumer takes the presented bomb.
REQ-013 count  output  clog2(DEPTH+1)  number of live bombs, including any being presented.

Function
REQ-014 SHALL store bombs in a FIFO of DEPTH entries; each entry holds {x, y, ts}, where ts is the timer value in the accept cycle.
- Equal fuse lengths make expiry order equal placement order.
REQ-015 When place_req=1 and count<DEPTH, SHALL write the entry and pulse place_ack in the next cycle.
REQ-016 When place_req=1 and count==DEPTH, SHALL pulse place_nack in the next cycle and leave the queue unchanged.
REQ-017 Accept/reject SHALL use count before any same-cycle pop.
- A full queue rejects even while popping.
REQ-018 Head age SHALL be (timer - head.ts) mod 4096, computed as a 12-bit unsigned subtraction.
- Wrap-around is correct by construction.
REQ-019 The head SHALL be expired when count>0 and age>=FUSE_TICKS.
REQ-020 The output FSM SHALL have two states:
- IDLE -> PRESENT on the cycle after the head is seen expired.
- PRESENT -> IDLE on the cycle explode_valid && explode_ready is seen.
REQ-021 In PRESENT, SHALL hold explode_valid=1 and keep explode_x/explode_y stable and equal to the head until accepted.
REQ-022 On acceptance, SHALL pop the head and deassert explode_valid in the next cycle.
- explode_valid SHALL be low for at least one cycle between presentations.
REQ-023 If a place and a pop occur in the same cycle, SHALL do both; count is unchanged.
REQ-024 explode_ready while explode_valid=0 SHALL have no effect.
REQ-025 explode_ready held low for more than 4096-FUSE_TICKS ticks is outside this block's operating range; results in that case are undefined.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Reset=1 SHALL immediately force:
- count=0
- FSM=IDLE
- place_ack=0, place_nack=0
- explode_valid=0
- explode_x=0, explode_y=0
REQ-028 Entry storage need not be cleared by reset.
REQ-029 Reset asserted mid-presentation SHALL discard all bombs; no explosion is emitted after release.

Configuration
REQ-030 With macro BOMB_DUP_CHECK_EN defined:
- A request whose (place_x, place_y) matches any live entry SHALL be rejected with place_nack.
- The match check SHALL be combinational over all DEPTH entries.
REQ-031 With BOMB_DUP_CHECK_EN undefined, duplicate coordinates SHALL be accepted as separate bombs.

Verification
REQ-032 Place (3,5) at timer=100, explode_ready=1 -> place_ack next cycle; explode_valid rises 1 cycle after timer reaches 292; x=3, y=5; count returns to 0.
REQ-033 Place at timer=4000 -> age wraps; explosion when timer=96 (4000+192-4096), not earlier.
REQ-034 Place 5 bombs at DEPTH=4 -> four place_acks, fifth place_nack, count=4.
REQ-035 Two bombs expired, explode_ready low for 10 cycles then high -> first bomb's x/y held stable throughout; the second is presented only after a valid-low gap cycle.
REQ-036 Full queue, place_req in the same cycle as a pop -> place_nack; count goes 4 -> 3.
REQ-037 With BOMB_DUP_CHECK_EN, place (2,2) twice -> ack then nack; Reset during PRESENT -> explode_valid=0 immediately and count=0.
